// File: rtl/pixel_color_stage_if.sv
// Signal bundle between the pixel fetch/timing logic, the palette RAM ports,
// the host write port and the DAC side of the pixel colour stage.
interface pixel_color_stage_if;
    logic        in_valid;
    logic [7:0]  in_index;
    logic        in_blank;
    logic        in_vblank;
    logic        in_hsync;
    logic        in_vsync;
    logic        pal_rd_n;
    logic [7:0]  pal_rd_addr;
    logic [15:0] pal_rd_data;
    logic        pal_wr_n;
    logic [7:0]  pal_wr_addr;
    logic [15:0] pal_wr_data;
    logic        host_wr_req;
    logic [7:0]  host_wr_addr;
    logic [15:0] host_wr_data;
    logic        host_wr_busy;
    logic        host_wr_done;
    logic [3:0]  out_r;
    logic [3:0]  out_g;
    logic [3:0]  out_b;
    logic        out_hsync;
    logic        out_vsync;
    logic        out_de;
    logic        out_underflow;

    modport master (
        output in_valid, in_index, in_blank, in_vblank, in_hsync, in_vsync,
        input  pal_rd_n, pal_rd_addr,
        output pal_rd_data,
        input  pal_wr_n, pal_wr_addr, pal_wr_data,
        output host_wr_req, host_wr_addr, host_wr_data,
        input  host_wr_busy, host_wr_done,
        input  out_r, out_g, out_b, out_hsync, out_vsync, out_de, out_underflow
    );

    modport slave (
        input  in_valid, in_index, in_blank, in_vblank, in_hsync, in_vsync,
        output pal_rd_n, pal_rd_addr,
        input  pal_rd_data,
        output pal_wr_n, pal_wr_addr, pal_wr_data,
        input  host_wr_req, host_wr_addr, host_wr_data,
        output host_wr_busy, host_wr_done,
        output out_r, out_g, out_b, out_hsync, out_vsync, out_de, out_underflow
    );
endinterface

// File: rtl/pixel_color_stage.sv
// Pixel output stage: palette lookup pipeline with matched sync/DE delay, plus a
// one-entry host write buffer that commits to the palette during vertical blank.
module pixel_color_stage #(
    parameter int          PAL_LAT      = 1,
    parameter bit          WR_ANYTIME   = 1'b0,
    parameter logic [11:0] BORDER_COLOR = 12'h000
) (
    input  logic                 clk,
    input  logic                 rst,
    pixel_color_stage_if.slave   bus
);
    localparam int L = 2 + PAL_LAT;
    // Carried-signal stages; the output register is the final stage.
    localparam int D = L - 1;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_PEND  = 2'd1,
        WR_WRITE = 2'd2
    } wr_state_t;

    logic [D-1:0] r_hs_d;
    logic [D-1:0] r_vs_d;
    logic [D-1:0] r_blank_d;
    logic [D-1:0] r_valid_d;
    logic         r_rd_n;
    logic [7:0]   r_rd_addr;
    logic [11:0]  r_out_rgb;
    logic         r_out_hs;
    logic         r_out_vs;
    logic         r_out_de;
    logic         r_out_uf;

    wr_state_t    r_wr_state;
    logic         r_wr_n;
    logic [7:0]   r_wr_addr;
    logic [15:0]  r_wr_data;
    logic         r_busy;
    logic         r_done;

    logic [11:0]  w_rgb;
    logic         w_de;
    logic         w_uf;
    logic         w_unused;

    assign w_unused = &{1'b0, bus.pal_rd_data[15:12]};

    // Pixel selection for the stage whose palette data is arriving this cycle.
    always_comb begin
        w_rgb = 12'h000;
        w_de  = 1'b0;
        w_uf  = 1'b0;
        if (r_blank_d[D-1]) begin
            w_rgb = 12'h000;
            w_de  = 1'b0;
            w_uf  = 1'b0;
        end else if (r_valid_d[D-1]) begin
            w_rgb = bus.pal_rd_data[11:0];
            w_de  = 1'b1;
            w_uf  = 1'b0;
        end else begin
            w_rgb = BORDER_COLOR;
            w_de  = 1'b1;
            w_uf  = 1'b1;
        end
    end

    // Read pipeline: palette address issue, sync/blank delay line, output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hs_d    <= '0;
            r_vs_d    <= '0;
            r_blank_d <= '0;
            r_valid_d <= '0;
            r_rd_n    <= 1'b1;
            r_rd_addr <= 8'h00;
            r_out_rgb <= 12'h000;
            r_out_hs  <= 1'b0;
            r_out_vs  <= 1'b0;
            r_out_de  <= 1'b0;
            r_out_uf  <= 1'b0;
        end else begin
            r_hs_d    <= {r_hs_d[D-2:0], bus.in_hsync};
            r_vs_d    <= {r_vs_d[D-2:0], bus.in_vsync};
            r_blank_d <= {r_blank_d[D-2:0], bus.in_blank};
            r_valid_d <= {r_valid_d[D-2:0], bus.in_valid};
            // Address holds its last value while no read is issued.
            if (bus.in_valid && !bus.in_blank) begin
                r_rd_n    <= 1'b0;
                r_rd_addr <= bus.in_index;
            end else begin
                r_rd_n    <= 1'b1;
            end
            r_out_rgb <= w_rgb;
            r_out_hs  <= r_hs_d[D-1];
            r_out_vs  <= r_vs_d[D-1];
            r_out_de  <= w_de;
            r_out_uf  <= w_uf;
        end
    end

    // Host write buffer FSM: latch one request, wait for vblank, write one cycle, report done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_state <= WR_IDLE;
            r_wr_n     <= 1'b1;
            r_wr_addr  <= 8'h00;
            r_wr_data  <= 16'h0000;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_wr_state)
                WR_IDLE: begin
                    r_wr_n <= 1'b1;
                    if (bus.host_wr_req) begin
                        r_wr_addr  <= bus.host_wr_addr;
                        r_wr_data  <= bus.host_wr_data;
                        r_busy     <= 1'b1;
                        r_wr_state <= WR_PEND;
                    end else begin
                        r_busy     <= 1'b0;
                    end
                end
                WR_PEND: begin
                    r_busy <= 1'b1;
                    if (bus.in_vblank || WR_ANYTIME) begin
                        r_wr_n     <= 1'b0;
                        r_wr_state <= WR_WRITE;
                    end else begin
                        r_wr_n     <= 1'b1;
                    end
                end
                WR_WRITE: begin
                    // Committed regardless of in_vblank now.
                    r_wr_n     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b1;
                    r_wr_state <= WR_IDLE;
                end
                default: begin
                    r_wr_n     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_wr_state <= WR_IDLE;
                end
            endcase
        end
    end

    assign bus.pal_rd_n      = r_rd_n;
    assign bus.pal_rd_addr   = r_rd_addr;
    assign bus.pal_wr_n      = r_wr_n;
    assign bus.pal_wr_addr   = r_wr_addr;
    assign bus.pal_wr_data   = r_wr_data;
    assign bus.host_wr_busy  = r_busy;
    assign bus.host_wr_done  = r_done;
    assign bus.out_r         = r_out_rgb[11:8];
    assign bus.out_g         = r_out_rgb[7:4];
    assign bus.out_b         = r_out_rgb[3:0];
    assign bus.out_hsync     = r_out_hs;
    assign bus.out_vsync     = r_out_vs;
    assign bus.out_de        = r_out_de;
    assign bus.out_underflow = r_out_uf;
endmodule

// File: tb/tb_pixel_color_stage.sv
// Directed bench for pixel_color_stage: table-driven pixel vectors against a palette
// RAM model, plus hand-written sequences for streaming and the host write buffer.
module tb_pixel_color_stage;
    localparam int          PAL_LAT = 2;
    localparam int          L       = 2 + PAL_LAT;
    localparam logic [11:0] BORDER  = 12'hABC;

    logic clk;
    logic rst;
    pixel_color_stage_if bus();

    pixel_color_stage #(
        .PAL_LAT      (PAL_LAT),
        .WR_ANYTIME   (1'b0),
        .BORDER_COLOR (BORDER)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Palette RAM model: registered read, PAL_LAT=2 clocks from address to data.
    logic [15:0] mem [256];
    logic [15:0] pd0;
    always @(posedge clk) begin
        if (!bus.pal_rd_n) pd0 <= mem[bus.pal_rd_addr];
        bus.pal_rd_data <= pd0;
    end

    // Write-port monitor, sampled mid-cycle.
    int wr_cnt, done_cnt, wr06_cnt;
    always @(negedge clk) begin
        if (!rst && !bus.pal_wr_n) begin
            wr_cnt++;
            if (bus.pal_wr_addr == 8'h06) wr06_cnt++;
        end
        if (bus.host_wr_done) done_cnt++;
    end

    int total, bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        valid;
        logic [7:0]  idx;
        logic        blank;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
        logic        de;
        logic        uf;
        logic        rdn;
    } vec_t;

    vec_t vecs[6];
    vec_t strm[3];

    task automatic drive_pix(input vec_t v);
        bus.in_valid = v.valid;
        bus.in_index = v.idx;
        bus.in_blank = v.blank;
        bus.in_hsync = v.hs;
        bus.in_vsync = v.vs;
    endtask

    task automatic drive_idle();
        bus.in_valid = 1'b0;
        bus.in_index = 8'h00;
        bus.in_blank = 1'b1;
        bus.in_hsync = 1'b0;
        bus.in_vsync = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input vec_t v);
        check({name, ".rgb"}, {20'h0, bus.out_r, bus.out_g, bus.out_b}, {20'h0, v.rgb});
        check({name, ".de"}, {31'h0, bus.out_de}, {31'h0, v.de});
        check({name, ".uf"}, {31'h0, bus.out_underflow}, {31'h0, v.uf});
        check({name, ".hs"}, {31'h0, bus.out_hsync}, {31'h0, v.hs});
        check({name, ".vs"}, {31'h0, bus.out_vsync}, {31'h0, v.vs});
    endtask

    int w0, d0, errs;

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h10] = 16'hF123;
        mem[8'h20] = 16'h0456;
        mem[8'h7F] = 16'h1FED;
        mem[8'hFF] = 16'h0999;

        vecs[0] = '{1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 12'h123, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'h20, 1'b0, 1'b0, 1'b1, 12'h456, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 8'h7F, 1'b0, 1'b1, 1'b1, 12'hFED, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, BORDER,  1'b1, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1};

        // Reset dominates valid pixels and host requests.
        rst = 1'b1;
        bus.in_valid     = 1'b1;
        bus.in_index     = 8'h10;
        bus.in_blank     = 1'b0;
        bus.in_vblank    = 1'b0;
        bus.in_hsync     = 1'b1;
        bus.in_vsync     = 1'b1;
        bus.host_wr_req  = 1'b1;
        bus.host_wr_addr = 8'h33;
        bus.host_wr_data = 16'h3333;
        step();
        step();
        check("rst.rd_n",  {31'h0, bus.pal_rd_n}, 32'h1);
        check("rst.wr_n",  {31'h0, bus.pal_wr_n}, 32'h1);
        check("rst.busy",  {31'h0, bus.host_wr_busy}, 32'h0);
        check("rst.done",  {31'h0, bus.host_wr_done}, 32'h0);
        check("rst.outs",  {8'h0, bus.out_r, bus.out_g, bus.out_b, bus.out_hsync,
                            bus.out_vsync, bus.out_de, bus.out_underflow, bus.pal_rd_addr},
                           32'h0);
        check("rst.wrbus", {8'h0, bus.pal_wr_addr, bus.pal_wr_data}, 32'h0);
        bus.host_wr_req = 1'b0;
        drive_idle();
        rst = 1'b0;
        repeat (L + 2) step();

        // Table vectors: one pixel surrounded by blank cycles.
        for (int i = 0; i < 6; i++) begin
            drive_pix(vecs[i]);
            step();
            check($sformatf("v%0d.rd_n", i), {31'h0, bus.pal_rd_n}, {31'h0, vecs[i].rdn});
            if (!vecs[i].rdn)
                check($sformatf("v%0d.rd_addr", i), {24'h0, bus.pal_rd_addr}, {24'h0, vecs[i].idx});
            drive_idle();
            repeat (L - 2) step();
            check($sformatf("v%0d.early_de", i), {31'h0, bus.out_de}, 32'h0);
            step();
            check_out($sformatf("v%0d", i), vecs[i]);
            step();
            check($sformatf("v%0d.late_de", i), {31'h0, bus.out_de}, 32'h0);
            check($sformatf("v%0d.late_uf", i), {31'h0, bus.out_underflow}, 32'h0);
            repeat (2) step();
        end

        // Back-to-back pixels: no stall, each colour lands on its own cycle.
        strm[0] = '{1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 12'h123, 1'b1, 1'b0, 1'b0};
        strm[1] = '{1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 12'h456, 1'b1, 1'b0, 1'b0};
        strm[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, BORDER,  1'b1, 1'b1, 1'b1};
        for (int k = 0; k < L + 4; k++) begin
            if (k < 3) drive_pix(strm[k]);
            else       drive_idle();
            if (k >= L && k - L < 3) check_out($sformatf("s%0d", k - L), strm[k - L]);
            step();
        end
        repeat (4) step();

        // Host write held through 100 non-vblank cycles; a second request is dropped.
        w0 = wr_cnt;
        d0 = done_cnt;
        bus.host_wr_req  = 1'b1;
        bus.host_wr_addr = 8'h05;
        bus.host_wr_data = 16'h0F0F;
        step();
        bus.host_wr_req = 1'b0;
        errs = 0;
        for (int c = 0; c < 100; c++) begin
            if (bus.host_wr_busy !== 1'b1 || bus.pal_wr_n !== 1'b1) errs++;
            if (c == 50) begin
                bus.host_wr_req  = 1'b1;
                bus.host_wr_addr = 8'h06;
                bus.host_wr_data = 16'h1111;
            end else begin
                bus.host_wr_req  = 1'b0;
            end
            step();
        end
        bus.host_wr_req = 1'b0;
        check("pend.busy_or_wr_errs", errs, 32'd0);
        check("pend.wr_cnt", wr_cnt - w0, 32'd0);
        bus.in_vblank = 1'b1;
        step();
        bus.in_vblank = 1'b0;
        check("w5.wr_n",  {31'h0, bus.pal_wr_n}, 32'h0);
        check("w5.addr",  {24'h0, bus.pal_wr_addr}, 32'h05);
        check("w5.data",  {16'h0, bus.pal_wr_data}, 32'h0F0F);
        check("w5.busy",  {31'h0, bus.host_wr_busy}, 32'h1);
        check("w5.done0", {31'h0, bus.host_wr_done}, 32'h0);
        step();
        check("w5.wr_n_after", {31'h0, bus.pal_wr_n}, 32'h1);
        check("w5.done",       {31'h0, bus.host_wr_done}, 32'h1);
        check("w5.busy_after", {31'h0, bus.host_wr_busy}, 32'h0);
        step();
        check("w5.done_pulse", {31'h0, bus.host_wr_done}, 32'h0);
        bus.in_vblank = 1'b1;
        repeat (20) step();
        bus.in_vblank = 1'b0;
        check("w5.total_writes", wr_cnt - w0, 32'd1);
        check("w5.total_done",   done_cnt - d0, 32'd1);
        check("w5.addr06_never", wr06_cnt, 32'd0);

        // Reset while a write is pending discards it silently.
        w0 = wr_cnt;
        d0 = done_cnt;
        bus.host_wr_req  = 1'b1;
        bus.host_wr_addr = 8'h08;
        bus.host_wr_data = 16'hAAAA;
        step();
        bus.host_wr_req = 1'b0;
        repeat (4) step();
        check("w6.busy_pend", {31'h0, bus.host_wr_busy}, 32'h1);
        rst = 1'b1;
        bus.in_vblank = 1'b1;
        step();
        rst = 1'b0;
        check("w6.busy_rst", {31'h0, bus.host_wr_busy}, 32'h0);
        repeat (10) step();
        check("w6.no_write", wr_cnt - w0, 32'd0);
        check("w6.no_done",  done_cnt - d0, 32'd0);
        bus.host_wr_req  = 1'b1;
        bus.host_wr_addr = 8'h07;
        bus.host_wr_data = 16'h1234;
        step();
        bus.host_wr_req = 1'b0;
        check("w6b.busy", {31'h0, bus.host_wr_busy}, 32'h1);
        step();
        check("w6b.wr_n", {31'h0, bus.pal_wr_n}, 32'h0);
        check("w6b.wr",   {8'h0, bus.pal_wr_addr, bus.pal_wr_data}, 32'h00071234);
        step();
        check("w6b.done", {31'h0, bus.host_wr_done}, 32'h1);
        check("w6b.busy_after", {31'h0, bus.host_wr_busy}, 32'h0);
        repeat (4) step();
        check("w6b.writes", wr_cnt - w0, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
